controlador_sumador_serial: RTL and testbench

Bit-serial adder controller. It sequences a single external 1-bit full-adder cell (ports A, B, Cin -> Suma, Cout) over ANCHO clock cycles to add two ANCHO-bit operands plus carry-in.
- Accepts one operation per Inicio request.
- Reports the result with a one-cycle Listo pulse.
- Sits between a requesting master (or bench) and the shared full-adder cell, which it owns exclusively while Ocupado=1.

---
 rtl/controlador_sumador_serial_if.sv | 23 ++
 rtl/controlador_sumador_serial.sv | 94 +++++++++
 tb/tb_controlador_sumador_serial.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/controlador_sumador_serial_if.sv
// rtl/controlador_sumador_serial_if.sv - request/result bus of the bit-serial adder controller
interface controlador_sumador_serial_if #(
  parameter int ANCHO = 8
);
  logic             Inicio;
  logic [ANCHO-1:0] OperandoA;
  logic [ANCHO-1:0] OperandoB;
  logic             AcarreoEntrada;
  logic             Ocupado;
  logic             Listo;
  logic [ANCHO-1:0] Resultado;
  logic             AcarreoSalida;

  modport master (
    output Inicio, OperandoA, OperandoB, AcarreoEntrada,
    input  Ocupado, Listo, Resultado, AcarreoSalida
  );

  modport slave (
    input  Inicio, OperandoA, OperandoB, AcarreoEntrada,
    output Ocupado, Listo, Resultado, AcarreoSalida
  );
endinterface

// File: rtl/controlador_sumador_serial.sv
// rtl/controlador_sumador_serial.sv - sequences an external 1-bit full adder over ANCHO cycles
module controlador_sumador_serial #(
  parameter int ANCHO  = 8,
  parameter int CONT_W = 6
) (
  input  logic                         Reloj,
  input  logic                         Reset_n,
  controlador_sumador_serial_if.slave  bus,
  output logic                         FA_A,
  output logic                         FA_B,
  output logic                         FA_Cin,
  input  logic                         FA_Suma,
  input  logic                         FA_Cout
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t           estado, estado_sig;
  logic [CONT_W-1:0] cont;
  logic [ANCHO-1:0]  reg_a, reg_b, parcial, parcial_sig, resultado_q;
  logic              acarreo, acarreo_sal_q;
  logic              ultimo_paso;

  assign ultimo_paso = (cont == CONT_W'(ANCHO - 1));
  // New sum bit enters at the MSB; after ANCHO steps bit 0 sits at the LSB.
  assign parcial_sig = ANCHO'({FA_Suma, parcial} >> 1);

  always_comb begin
    estado_sig = estado;
    FA_A       = 1'b0;
    FA_B       = 1'b0;
    FA_Cin     = 1'b0;
    unique case (estado)
      REPOSO:  if (bus.Inicio) estado_sig = SUMANDO;
      SUMANDO: begin
        FA_A   = reg_a[0];
        FA_B   = reg_b[0];
        FA_Cin = acarreo;
        if (ultimo_paso) estado_sig = FIN;
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) estado <= REPOSO;
    else          estado <= estado_sig;
  end

  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      cont          <= '0;
      reg_a         <= '0;
      reg_b         <= '0;
      acarreo       <= 1'b0;
      parcial       <= '0;
      resultado_q   <= '0;
      acarreo_sal_q <= 1'b0;
    end else begin
      case (estado)
        REPOSO: if (bus.Inicio) begin
          reg_a   <= bus.OperandoA;
          reg_b   <= bus.OperandoB;
          acarreo <= bus.AcarreoEntrada;
          cont    <= '0;
        end
        SUMANDO: begin
          parcial <= parcial_sig;
          reg_a   <= reg_a >> 1;
          reg_b   <= reg_b >> 1;
          acarreo <= FA_Cout;
          cont    <= cont + CONT_W'(1);
          // Publish only the finished sum so partial values never reach Resultado.
          if (ultimo_paso) begin
            resultado_q   <= parcial_sig;
            acarreo_sal_q <= FA_Cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Ocupado       = (estado != REPOSO);
  assign bus.Listo         = (estado == FIN);
  assign bus.Resultado     = resultado_q;
  assign bus.AcarreoSalida = acarreo_sal_q;

endmodule

// File: tb/tb_controlador_sumador_serial.sv
// tb/tb_controlador_sumador_serial.sv - scoreboard bench for the bit-serial adder controller
module tb_controlador_sumador_serial;

  logic reloj = 1'b0;
  logic reset_n;
  always #5 reloj = ~reloj;

  controlador_sumador_serial_if #(.ANCHO(8)) bus ();
  controlador_sumador_serial_if #(.ANCHO(1)) bus1 ();

  logic fa_a, fa_b, fa_cin, fa_suma, fa_cout;
  logic fa1_a, fa1_b, fa1_cin, fa1_suma, fa1_cout;

  assign fa_suma  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa1_suma = fa1_a ^ fa1_b ^ fa1_cin;
  assign fa1_cout = (fa1_a & fa1_b) | (fa1_a & fa1_cin) | (fa1_b & fa1_cin);

  controlador_sumador_serial #(.ANCHO(8), .CONT_W(6)) dut (
    .Reloj(reloj), .Reset_n(reset_n), .bus(bus),
    .FA_A(fa_a), .FA_B(fa_b), .FA_Cin(fa_cin), .FA_Suma(fa_suma), .FA_Cout(fa_cout)
  );

  controlador_sumador_serial #(.ANCHO(1), .CONT_W(2)) dut1 (
    .Reloj(reloj), .Reset_n(reset_n), .bus(bus1),
    .FA_A(fa1_a), .FA_B(fa1_b), .FA_Cin(fa1_cin), .FA_Suma(fa1_suma), .FA_Cout(fa1_cout)
  );

  int         vectores = 0;
  int         fallos = 0;
  int         ciclo = 0;
  int         ultimo_listo = 0;
  logic [8:0] esperado_q[$];
  logic [8:0] previo;

  always @(posedge reloj) ciclo <= ciclo + 1;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectores++;
    assert (obs === exp) else begin
      fallos++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lanzar(input logic [7:0] a, input logic [7:0] b, input logic cin);
    bus.OperandoA      = a;
    bus.OperandoB      = b;
    bus.AcarreoEntrada = cin;
    bus.Inicio         = 1'b1;
    esperado_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
  endtask

  // Starts at a negedge with Inicio high in REPOSO; returns at the negedge where Listo is seen.
  task automatic esperar_listo(input logic [63:0] mascara, input bit chequear_intervalo,
                               output int ciclos, output logic [7:0] fa_seq);
    logic [8:0] esp;
    bit         estable;
    ciclos  = 0;
    fa_seq  = '0;
    estable = 1'b1;
    @(posedge reloj);
    while (1) begin
      @(negedge reloj);
      ciclos++;
      if (ciclos <= 8) fa_seq[ciclos-1] = fa_a;
      if (ciclos == 1) begin
        bus.OperandoA      = 8'hAA;
        bus.OperandoB      = 8'h55;
        bus.AcarreoEntrada = 1'b1;
      end
      bus.Inicio = mascara[ciclos];
      if (bus.Listo) break;
      if (bus.Resultado !== previo[7:0] || bus.AcarreoSalida !== previo[8]) estable = 1'b0;
      if (ciclos >= 30) break;
    end
    comprobar("listo_seen", 32'(bus.Listo), 32'd1);
    if (bus.Listo && esperado_q.size() > 0) begin
      esp = esperado_q.pop_front();
      comprobar("suma", 32'({bus.AcarreoSalida, bus.Resultado}), 32'(esp));
      comprobar("ocupado_en_fin", 32'(bus.Ocupado), 32'd1);
      comprobar("resultado_estable", 32'(estable), 32'd1);
      if (chequear_intervalo) comprobar("intervalo", 32'(ciclo - ultimo_listo), 32'd10);
      ultimo_listo = ciclo;
      previo       = esp;
    end
  endtask

  initial begin
    int         ciclos;
    logic [7:0] seq;
    bit         limpio;

    reset_n             = 1'b0;
    bus.Inicio          = 1'b0;
    bus.OperandoA       = '0;
    bus.OperandoB       = '0;
    bus.AcarreoEntrada  = 1'b0;
    bus1.Inicio         = 1'b0;
    bus1.OperandoA      = '0;
    bus1.OperandoB      = '0;
    bus1.AcarreoEntrada = 1'b0;
    previo              = '0;

    repeat (2) @(negedge reloj);
    comprobar("rst_ocupado", 32'(bus.Ocupado), 32'd0);
    comprobar("rst_listo", 32'(bus.Listo), 32'd0);
    comprobar("rst_resultado", 32'({bus.AcarreoSalida, bus.Resultado}), 32'd0);
    comprobar("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    reset_n = 1'b1;
    @(negedge reloj);

    lanzar(8'h5A, 8'h33, 1'b0);
    esperar_listo(64'd0, 1'b0, ciclos, seq);
    comprobar("t1_latencia", 32'(ciclos), 32'd9);
    comprobar("t1_fa_a_seq", 32'(seq), 32'h5A);
    comprobar("t1_resultado", 32'({bus.AcarreoSalida, bus.Resultado}), 32'h08D);
    @(negedge reloj);
    comprobar("t1_listo_un_ciclo", 32'(bus.Listo), 32'd0);
    comprobar("t1_retiene", 32'(bus.Resultado), 32'h8D);

    lanzar(8'hFF, 8'h01, 1'b0);
    esperar_listo(64'd0, 1'b0, ciclos, seq);
    comprobar("t2a_resultado", 32'({bus.AcarreoSalida, bus.Resultado}), 32'h100);
    @(negedge reloj);
    lanzar(8'hFF, 8'hFF, 1'b1);
    esperar_listo(64'd0, 1'b0, ciclos, seq);
    comprobar("t2b_resultado", 32'({bus.AcarreoSalida, bus.Resultado}), 32'h1FF);
    @(negedge reloj);

    lanzar(8'h10, 8'h20, 1'b0);
    esperar_listo(64'h208, 1'b0, ciclos, seq);
    comprobar("t3_latencia", 32'(ciclos), 32'd9);
    comprobar("t3_resultado", 32'({bus.AcarreoSalida, bus.Resultado}), 32'h030);
    @(negedge reloj);
    bus.Inicio = 1'b0;
    limpio = 1'b1;
    repeat (12) begin
      if (bus.Listo || bus.Ocupado) limpio = 1'b0;
      @(negedge reloj);
    end
    comprobar("t3_sin_encolar", 32'(limpio), 32'd1);
    lanzar(8'hAA, 8'h11, 1'b1);
    esperar_listo(64'd0, 1'b0, ciclos, seq);
    comprobar("t3_siguiente", 32'({bus.AcarreoSalida, bus.Resultado}), 32'h0BC);
    @(negedge reloj);

    bus.OperandoA      = 8'h0F;
    bus.OperandoB      = 8'h0F;
    bus.AcarreoEntrada = 1'b0;
    bus.Inicio         = 1'b1;
    @(posedge reloj);
    @(negedge reloj);
    bus.Inicio = 1'b0;
    repeat (3) @(negedge reloj);
    comprobar("t4_fa_a_activo", 32'(fa_a), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    comprobar("t4_ocupado", 32'(bus.Ocupado), 32'd0);
    comprobar("t4_listo", 32'(bus.Listo), 32'd0);
    comprobar("t4_resultado", 32'({bus.AcarreoSalida, bus.Resultado}), 32'd0);
    comprobar("t4_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
    @(negedge reloj);
    reset_n = 1'b1;
    previo  = '0;
    limpio  = 1'b1;
    repeat (15) begin
      @(negedge reloj);
      if (bus.Listo || bus.Ocupado) limpio = 1'b0;
    end
    comprobar("t4_sin_listo", 32'(limpio), 32'd1);
    lanzar(8'h0F, 8'h0F, 1'b0);
    esperar_listo(64'd0, 1'b0, ciclos, seq);
    comprobar("t4_resultado_nuevo", 32'({bus.AcarreoSalida, bus.Resultado}), 32'h01E);
    @(negedge reloj);

    for (int i = 0; i < 500; i++) begin
      lanzar(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      esperar_listo({64{1'b1}}, i > 0, ciclos, seq);
      @(negedge reloj);
    end
    bus.Inicio = 1'b0;
    comprobar("t5_cola_vacia", 32'(esperado_q.size()), 32'd0);

    bus1.OperandoA      = 1'b1;
    bus1.OperandoB      = 1'b1;
    bus1.AcarreoEntrada = 1'b1;
    bus1.Inicio         = 1'b1;
    @(posedge reloj);
    ciclos = 0;
    while (ciclos < 10) begin
      @(negedge reloj);
      ciclos++;
      if (ciclos == 1) begin
        comprobar("t6_fa", 32'({fa1_a, fa1_b, fa1_cin}), 32'h7);
        bus1.Inicio    = 1'b0;
        bus1.OperandoA = 1'b0;
        bus1.OperandoB = 1'b0;
      end
      if (bus1.Listo) break;
    end
    comprobar("t6_latencia", 32'(ciclos), 32'd2);
    comprobar("t6_resultado", 32'({bus1.AcarreoSalida, bus1.Resultado}), 32'h3);
    @(negedge reloj);
    comprobar("t6_vuelta_reposo", 32'({bus1.Listo, bus1.Ocupado}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
    $finish;
  end

endmodule
